forwarding_scoreboard: RTL and testbench
========================================

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 Parameter REG_AW, default 4: register-index width.
REQ-002 Parameter NUM_SRC, default 2: number of source operands checked per issued instruction.
REQ-003 Parameter DEPTH, default 3: number of in-flight pipeline stages tracked (stage 1 = youngest).
REQ-004 Parameter LOAD_LAT, default 2: first stage index at which load data is forwardable.
REQ-005 Parameter SW = clog2(DEPTH+1): select width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 id_valid  in  1  an instruction is presented for issue this cycle.
REQ-009 id_wb_en  in  1  presented instruction writes a register.
REQ-010 id_mem_read  in  1  presented instruction is a load.
REQ-011 id_dest  in  REG_AW  destination register of presented instruction.
REQ-012 id_src  in  NUM_SRC*REG_AW  source indices, source i at bits [i*REG_AW +: REG_AW].
REQ-013 id_src_used  in  NUM_SRC  per-source "operand actually read" flag.
REQ-014 flush  in  1  kill all in-flight entries (branch taken).
REQ-015 sel_src  out  NUM_SRC*SW  per-source select: 0 = register file, k = forward from stage k.
REQ-016 stall  out  1  hold issue; presented instruction not accepted this cycle.
REQ-017 stall_cnt  out  16  saturating count of stall cycles since reset.

Function
REQ-018 Scoreboard holds DEPTH entries {valid, wb_en, is_load, dest}; sel_src and stall are combinational from entries and current inputs.
REQ-019 For each source i with id_src_used[i]=1, match(k) = entry k valid & wb_en & dest==src i.
REQ-020 sel_src[i] = smallest k with match(k) (youngest writer wins); 0 if none or id_src_used[i]=0 or id_valid=0.
REQ-021 stall = 1 when id_valid=1 and, for any used source, the youngest matching entry k has is_load=1 and k < LOAD_LAT.
REQ-022 While stall=1, sel_src outputs are don't-care to the consumer but remain computed per REQ-020.
REQ-023 Each rising edge without flush: entry k <= entry k-1 for k=2..DEPTH; entry DEPTH is discarded.
REQ-024 Entry 1 <= {1, id_wb_en, id_mem_read, id_dest} when id_valid=1 and stall=0; otherwise entry 1 <= bubble (valid=0).
REQ-025 Accepted-instruction latency: visible as stage k exactly k cycles after acceptance.
REQ-026 flush=1: all entries <= invalid on that edge, overriding shift and insertion; stall_cnt still counts a concurrent stall.
REQ-027 Dest register 0 is tracked like any other index (no hard-wired zero register).
REQ-028 stall_cnt increments by 1 on each edge where stall=1; holds at 16'hFFFF.
REQ-029 Stall resolves without external action: the load advances one stage per cycle and stall drops once k reaches LOAD_LAT.

Reset
REQ-030 rst=1 at an edge: all entries invalid, stall_cnt=0; takes priority over flush and insertion.
REQ-031 During and after reset: sel_src=0, stall=0 until an entry becomes valid.
REQ-032 Reset mid-stall aborts the stall; the next cycle issues with no hazards.

Configuration
REQ-033 Macro FWD_PATH_EN defined: forwarding behaviour per REQ-020/REQ-021.
REQ-034 FWD_PATH_EN undefined: sel_src forced to 0; stall=1 whenever any used source matches any stage k (any instruction type); scoreboard, shift, flush and counter are unchanged.

Verification
REQ-035 Issue ADD r3 (wb), next cycle issue SUB with src0=r3 -> sel_src[0]=1, stall=0.
REQ-036 Entries r5 at stages 1 and 2, issue src1=r5 -> sel_src[1]=1 (youngest); with only stage 3 = r5 -> sel_src[1]=3.
REQ-037 LDR r2, then immediately src0=r2 (LOAD_LAT=2) -> stall=1 for exactly 1 cycle, stall_cnt=1, then sel_src[0]=2 and issue accepted.
REQ-038 Same load-use with flush asserted during the stall cycle -> entries cleared, next cycle stall=0, sel_src=0, stall_cnt=1.
REQ-039 FWD_PATH_EN undefined, ADD r7 then src0=r7 -> stall=1 for DEPTH cycles (3), sel_src=0 throughout, then accept.
REQ-040 rst asserted while stall=1 with stall_cnt=5 -> next cycle stall=0, stall_cnt=0, all sel_src=0.

Source files
------------

// File: rtl/forwarding_scoreboard.sv
// In-flight writer scoreboard with operand-forwarding selects and load-use stall detection.
// Build option: define FWD_PATH_EN to enable forwarding; otherwise any in-flight match stalls issue.
module forwarding_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_wb_en,
  input  logic                      id_mem_read,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      flush,
  output logic [NUM_SRC*SW-1:0]     sel_src,
  output logic                      stall,
  output logic [15:0]               stall_cnt
);

  logic [DEPTH-1:0]  r_vld;
  logic [DEPTH-1:0]  r_wb;
  logic [DEPTH-1:0]  r_ld;
  logic [REG_AW-1:0] r_dest [DEPTH];
  logic [15:0]       r_stall_cnt;

  logic [SW-1:0]      w_sel [NUM_SRC];
  logic [NUM_SRC-1:0] w_ld_young;
  logic               w_accept;

  // Scan oldest to youngest so the youngest matching writer is the last one kept.
  always_comb begin
    w_ld_young = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel[i] = '0;
      if (id_valid && id_src_used[i]) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (r_vld[k-1] && r_wb[k-1] &&
              (r_dest[k-1] == id_src[i*REG_AW +: REG_AW])) begin
            w_sel[i]      = SW'(k);
            w_ld_young[i] = r_ld[k-1] && (k < LOAD_LAT);
          end
        end
      end
    end
  end

  // A load-use hazard is always a match, so it is part of the stall term in both builds.
  always_comb begin
    sel_src = '0;
    stall   = |w_ld_young;
`ifdef FWD_PATH_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_src[i*SW +: SW] = w_sel[i];
    end
`else
    for (int i = 0; i < NUM_SRC; i++) begin
      stall = stall | (w_sel[i] != '0);
    end
`endif
  end

  assign w_accept  = id_valid & ~stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush) begin
        r_vld <= '0;
      end else begin
        r_vld <= (r_vld << 1) | DEPTH'(w_accept);
      end
    end
  end

  // Payload follows the valid bits; contents of invalid entries are never observed.
  always_ff @(posedge clk) begin
    r_wb      <= (r_wb << 1) | DEPTH'(id_wb_en);
    r_ld      <= (r_ld << 1) | DEPTH'(id_mem_read);
    r_dest[0] <= id_dest;
    for (int k = 1; k < DEPTH; k++) begin
      r_dest[k] <= r_dest[k-1];
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed hazard scenarios plus random traffic against a queue-style model.
module tb_forwarding_scoreboard;
  localparam int REG_AW   = 4;
  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int SW       = $clog2(DEPTH + 1);

  logic                      clk;
  logic                      rst;
  logic                      id_valid;
  logic                      id_wb_en;
  logic                      id_mem_read;
  logic [REG_AW-1:0]         id_dest;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic                      flush;
  logic [NUM_SRC*SW-1:0]     sel_src;
  logic                      stall;
  logic [15:0]               stall_cnt;

  forwarding_scoreboard #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_dest(id_dest), .id_src(id_src),
    .id_src_used(id_src_used), .flush(flush), .sel_src(sel_src),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       wb;
    bit       ld;
    bit [3:0] d;
  } ent_t;

  ent_t m_pipe [DEPTH];   // m_pipe[k-1] is the instruction k cycles past acceptance
  int   m_cnt;
  int   e_sel [NUM_SRC];
  bit   e_stall;

  int   n_cmp;
  int   n_bad;
  int   obs_sel [NUM_SRC];
  int   obs_stall;
  int   obs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    e_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int  youngest;
      bit  found;
      youngest = 0;
      found    = 1'b0;
      if (id_valid && id_src_used[i]) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (!found && m_pipe[k-1].v && m_pipe[k-1].wb &&
              (m_pipe[k-1].d == id_src[i*REG_AW +: REG_AW])) begin
            youngest = k;
            found    = 1'b1;
          end
        end
      end
`ifdef FWD_PATH_EN
      e_sel[i] = youngest;
      if (found && m_pipe[youngest-1].ld && (youngest < LOAD_LAT)) e_stall = 1'b1;
`else
      e_sel[i] = 0;
      if (found) e_stall = 1'b1;
`endif
    end
  endtask

  task automatic model_step();
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_pipe[k].v = 1'b0;
      m_cnt = 0;
    end else begin
      if (e_stall && (m_cnt < 65535)) m_cnt++;
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) m_pipe[k].v = 1'b0;
      end else begin
        for (int k = DEPTH - 1; k >= 1; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0].v  = id_valid && !e_stall;
        m_pipe[0].wb = id_wb_en;
        m_pipe[0].ld = id_mem_read;
        m_pipe[0].d  = id_dest;
      end
    end
  endtask

  task automatic cyc();
    model_eval();
    @(negedge clk);
    obs_stall = int'(stall);
    obs_cnt   = int'(stall_cnt);
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    for (int i = 0; i < NUM_SRC; i++) begin
      obs_sel[i] = int'(sel_src[i*SW +: SW]);
      check($sformatf("sel%0d", i), obs_sel[i], e_sel[i]);
    end
    check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input bit wb, input bit ld, input int dest,
                       input int s0, input int s1, input bit [1:0] used,
                       input bit fl, input bit r);
    id_valid    = v;
    id_wb_en    = wb;
    id_mem_read = ld;
    id_dest     = REG_AW'(dest);
    id_src      = {REG_AW'(s1), REG_AW'(s0)};
    id_src_used = used;
    flush       = fl;
    rst         = r;
  endtask

  task automatic reset_seq();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    for (int k = 0; k < DEPTH; k++) m_pipe[k] = '{v: 1'b0, wb: 1'b0, ld: 1'b0, d: 4'd0};
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    @(posedge clk);
    #1;

    reset_seq();
    drive(1, 1, 0, 0, 0, 0, 2'b11, 0, 0);
    cyc();
    check("rst_stall", obs_stall, 0);
    check("rst_cnt", obs_cnt, 0);

`ifdef FWD_PATH_EN
    reset_seq();
    drive(1, 1, 0, 3, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 1, 0, 4, 3, 1, 2'b01, 0, 0); cyc();
    check("add_sub_sel0", obs_sel[0], 1);
    check("add_sub_stall", obs_stall, 0);

    reset_seq();
    drive(1, 1, 0, 5, 0, 0, 2'b00, 0, 0); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 5, 2'b10, 0, 0); cyc();
    check("youngest_sel1", obs_sel[1], 1);
    reset_seq();
    drive(1, 1, 0, 5, 0, 0, 2'b00, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 5, 2'b10, 0, 0); cyc();
    check("stage3_sel1", obs_sel[1], 3);

    reset_seq();
    drive(1, 1, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 1, 0, 6, 2, 0, 2'b01, 0, 0); cyc();
    check("ldu_stall", obs_stall, 1);
    cyc();
    check("ldu_release", obs_stall, 0);
    check("ldu_sel0", obs_sel[0], 2);
    check("ldu_cnt", obs_cnt, 1);
`else
    reset_seq();
    drive(1, 1, 0, 7, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 1, 0, 8, 7, 0, 2'b01, 0, 0);
    for (int c = 0; c < DEPTH; c++) begin
      cyc();
      check($sformatf("nofwd_stall_c%0d", c), obs_stall, 1);
      check($sformatf("nofwd_sel0_c%0d", c), obs_sel[0], 0);
    end
    cyc();
    check("nofwd_release", obs_stall, 0);
    check("nofwd_cnt", obs_cnt, DEPTH);
`endif

    reset_seq();
    drive(1, 1, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 1, 0, 6, 2, 0, 2'b01, 1, 0); cyc();
    check("flush_stall", obs_stall, 1);
    drive(1, 1, 0, 6, 2, 0, 2'b01, 0, 0); cyc();
    check("flush_after_stall", obs_stall, 0);
    check("flush_after_sel0", obs_sel[0], 0);
    check("flush_after_cnt", obs_cnt, 1);

    reset_seq();
    for (int r = 0; r < 5; r++) begin
      drive(1, 1, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
      drive(1, 1, 0, 6, 2, 0, 2'b01, 0, 0); cyc();
    end
    drive(1, 1, 1, 2, 0, 0, 2'b00, 0, 0); cyc();
    drive(1, 1, 0, 6, 2, 0, 2'b01, 0, 1); cyc();
    check("midrst_stall", obs_stall, 1);
    check("midrst_cnt", obs_cnt, 5);
    drive(1, 1, 0, 6, 2, 2, 2'b11, 0, 0); cyc();
    check("postrst_stall", obs_stall, 0);
    check("postrst_cnt", obs_cnt, 0);
    check("postrst_sel0", obs_sel[0], 0);
    check("postrst_sel1", obs_sel[1], 0);

    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) < 3,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
